// File: rtl/cache_fill_fsm.sv
`timescale 1ns/1ps
// cache_fill_fsm
// Cache miss handler. When the cache reports a miss, this block reads the
// whole 8-word block from main memory. Each returned word is written into the
// cache data array. The block then writes the tag and releases the stall.
//
// Ports
//   clk                 system clock, rising edge
//   rst_n               asynchronous active-low reset
//   miss_detected       cache miss indication (sampled in IDLE only)
//   miss_address[15:0]  byte address that missed
//   memory_data[15:0]   read data from main memory
//   memory_data_valid   memory_data holds the next outstanding read (in order)
//   fsm_busy            pipeline stall request (combinational on miss)
//   memory_read         one-cycle read request to memory
//   memory_address      word address of the read request
//   write_data_array    cache data array write strobe
//   write_tag_array     cache tag array write strobe
//   cache_fill_address  cache address used during a fill
//   cache_fill_data     cache write data
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a miss; all fill outputs held at 0
// FILL  | issuing 8 reads and writing returned words into the data array
// TAG   | one cycle: write the tag for the filled block, then back to IDLE

module cache_fill_fsm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        miss_detected,
  input  logic [15:0] miss_address,
  input  logic [15:0] memory_data,
  input  logic        memory_data_valid,
  output logic        fsm_busy,
  output logic        memory_read,
  output logic [15:0] memory_address,
  output logic        write_data_array,
  output logic        write_tag_array,
  output logic [15:0] cache_fill_address,
  output logic [15:0] cache_fill_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    TAG  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] base_q, base_d;
  logic [3:0]  issue_cnt_q, issue_cnt_d;
  logic [3:0]  recv_cnt_q, recv_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    base_d             = base_q;
    issue_cnt_d        = issue_cnt_q;
    recv_cnt_d         = recv_cnt_q;
    fsm_busy           = 1'b0;
    memory_read        = 1'b0;
    memory_address     = '0;
    write_data_array   = 1'b0;
    write_tag_array    = 1'b0;
    cache_fill_address = '0;
    cache_fill_data    = '0;

    case (state_q)
      IDLE: begin
        // Stall in the same cycle the miss is seen.
        fsm_busy = miss_detected;
        if (miss_detected) begin
          base_d      = miss_address[15:4];
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
          state_d     = FILL;
        end
      end

      FILL: begin
        fsm_busy = 1'b1;
        // Issue and receive sides run independently. Bit 3 of each counter
        // marks that all 8 words are done on that side.
        if (!issue_cnt_q[3]) begin
          memory_read    = 1'b1;
          memory_address = {base_q, issue_cnt_q[2:0], 1'b0};
          issue_cnt_d    = issue_cnt_q + 4'd1;
        end
        if (memory_data_valid && !recv_cnt_q[3]) begin
          write_data_array   = 1'b1;
          cache_fill_address = {base_q, recv_cnt_q[2:0], 1'b0};
          cache_fill_data    = memory_data;
          recv_cnt_d         = recv_cnt_q + 4'd1;
          if (recv_cnt_q == 4'd7) begin
            state_d = TAG;
          end
        end
      end

      TAG: begin
        fsm_busy           = 1'b1;
        write_tag_array    = 1'b1;
        cache_fill_address = {base_q, 4'b0000};
        state_d            = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
`timescale 1ns/1ps
// Testbench for cache_fill_fsm: a vector table for one short fill, plus
// scoreboard-driven fills against a latency-based memory model.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = '0;
  logic [15:0] memory_data = '0;
  logic        memory_data_valid = 1'b0;
  logic        fsm_busy, memory_read, write_data_array, write_tag_array;
  logic [15:0] memory_address, cache_fill_address, cache_fill_data;

  cache_fill_fsm dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .miss_detected      (miss_detected),
    .miss_address       (miss_address),
    .memory_data        (memory_data),
    .memory_data_valid  (memory_data_valid),
    .fsm_busy           (fsm_busy),
    .memory_read        (memory_read),
    .memory_address     (memory_address),
    .write_data_array   (write_data_array),
    .write_tag_array    (write_tag_array),
    .cache_fill_address (cache_fill_address),
    .cache_fill_data    (cache_fill_data)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mem_val(input logic [15:0] a);
    return 16'h1000 + {13'd0, a[3:1]};
  endfunction

  typedef struct { int due; logic [15:0] data; } pend_t;
  typedef struct { logic [15:0] addr; logic [15:0] data; } wr_t;
  pend_t       pend_q[$];
  wr_t         exp_wr[$];
  logic [15:0] rd_log[$];
  logic [15:0] tag_log[$];
  int busy_cnt, wr_cnt, cyc, lat;
  bit hold, spurious, tag_now;

  // Simple model of the direct-mapped cache fed by the DUT write strobes.
  logic [15:0] c_data [128][8];
  logic [4:0]  c_tag  [128];
  logic        c_val  [128];

  task automatic monitor();
    tag_now = 1'b0;
    if (fsm_busy) busy_cnt++;
    if (memory_read) begin
      pend_q.push_back('{cyc + lat, mem_val(memory_address)});
      exp_wr.push_back('{memory_address, mem_val(memory_address)});
      rd_log.push_back(memory_address);
    end
    if (write_data_array) begin
      wr_cnt++;
      if (exp_wr.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %h data %h, expected no write",
                 cache_fill_address, cache_fill_data);
      end else begin
        wr_t e;
        e = exp_wr.pop_front();
        chk("wr_addr", {16'd0, cache_fill_address}, {16'd0, e.addr});
        chk("wr_data", {16'd0, cache_fill_data}, {16'd0, e.data});
      end
      c_data[cache_fill_address[10:4]][cache_fill_address[3:1]] = cache_fill_data;
    end
    if (write_tag_array) begin
      tag_now = 1'b1;
      tag_log.push_back(cache_fill_address);
      c_tag[cache_fill_address[10:4]] = cache_fill_address[15:11];
      c_val[cache_fill_address[10:4]] = 1'b1;
    end
  endtask

  task automatic drive_mem();
    memory_data_valid = 1'b0;
    memory_data = '0;
    if (!hold && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      memory_data_valid = 1'b1;
      memory_data = pend_q[0].data;
      pend_q.delete(0);
    end else if (spurious) begin
      memory_data_valid = 1'b1;
      memory_data = 16'hDEAD;
    end
  endtask

  task automatic cycle_auto(input logic miss, input logic [15:0] a);
    miss_detected = miss;
    miss_address = a;
    drive_mem();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_sb();
    pend_q.delete();
    exp_wr.delete();
    rd_log.delete();
    tag_log.delete();
    busy_cnt = 0;
    wr_cnt = 0;
    hold = 1'b0;
    spurious = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    miss_detected = 1'b0;
    miss_address = '0;
    memory_data_valid = 1'b0;
    memory_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_fill(input logic [15:0] a, input int lat_i, input int ncyc,
                          input int hold_after, input int hold_len, input bit spur_en,
                          input int inj_cycle, input logic [15:0] inj_addr,
                          input bit b2b, input logic [15:0] b2b_addr);
    int hold_left;
    bit b2b_go, b2b_done;
    hold_left = hold_len;
    b2b_go = 1'b0;
    b2b_done = 1'b0;
    clear_sb();
    lat = lat_i;
    for (int k = 0; k < ncyc; k++) begin
      logic m;
      logic [15:0] ma;
      m = (k == 0);
      ma = a;
      if (k == inj_cycle) begin
        m = 1'b1;
        ma = inj_addr;
      end
      if (b2b_go) begin
        m = 1'b1;
        ma = b2b_addr;
        b2b_go = 1'b0;
        b2b_done = 1'b1;
      end
      hold = (hold_after > 0 && wr_cnt == hold_after && hold_left > 0);
      if (hold) hold_left--;
      spurious = spur_en && (wr_cnt >= 8);
      cycle_auto(m, ma);
      if (b2b && tag_now && !b2b_done) b2b_go = 1'b1;
    end
  endtask

  task automatic check_reads(input string name, input logic [15:0] base, input int off);
    for (int i = 0; i < 8; i++) begin
      if (off + i < rd_log.size())
        chk(name, {16'd0, rd_log[off + i]}, {16'd0, base + 16'(2 * i)});
      else
        chk({name, "_missing"}, 32'(rd_log.size()), 32'(off + 8));
    end
  endtask

  task automatic check_fill(input string name, input logic [15:0] base, input int busy_exp);
    chk({name, "_busy_cycles"}, 32'(busy_cnt), 32'(busy_exp));
    chk({name, "_nwrites"}, 32'(wr_cnt), 32'd8);
    chk({name, "_nreads"}, 32'(rd_log.size()), 32'd8);
    check_reads({name, "_read_addr"}, base, 0);
    chk({name, "_ntags"}, 32'(tag_log.size()), 32'd1);
    if (tag_log.size() > 0) chk({name, "_tag_addr"}, {16'd0, tag_log[0]}, {16'd0, base});
    chk({name, "_pending_writes"}, 32'(exp_wr.size()), 32'd0);
  endtask

  typedef struct {
    logic miss; logic [15:0] maddr; logic valid; logic [15:0] mdata;
    logic busy; logic rd; logic [15:0] raddr; logic wd; logic wt;
    logic [15:0] fa; logic [15:0] fd;
  } vec_t;
  vec_t tbl[13];

  task automatic check_outputs_zero(input string name);
    chk({name, "_busy"}, {31'd0, fsm_busy}, 32'd0);
    chk({name, "_read"}, {31'd0, memory_read}, 32'd0);
    chk({name, "_maddr"}, {16'd0, memory_address}, 32'd0);
    chk({name, "_wd"}, {31'd0, write_data_array}, 32'd0);
    chk({name, "_wt"}, {31'd0, write_tag_array}, 32'd0);
    chk({name, "_fa"}, {16'd0, cache_fill_address}, 32'd0);
    chk({name, "_fd"}, {16'd0, cache_fill_data}, 32'd0);
  endtask

  initial begin
    cyc = 0;
    lat = 1;
    for (int i = 0; i < 128; i++) begin
      c_val[i] = 1'b0;
      c_tag[i] = '0;
    end

    // Reset state, including fsm_busy following miss_detected.
    #1;
    check_outputs_zero("reset");
    miss_detected = 1'b1;
    #1;
    chk("reset_busy_follows_miss", {31'd0, fsm_busy}, 32'd1);
    chk("reset_no_read", {31'd0, memory_read}, 32'd0);
    do_reset();

    // Vector table: miss at 0x0127, memory latency 1, data 0xA000+i.
    for (int r = 0; r < 13; r++) tbl[r] = '{1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0};
    tbl[0].miss = 1'b1; tbl[0].maddr = 16'h0127; tbl[0].busy = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tbl[k].busy = 1'b1;
      tbl[k].rd = 1'b1;
      tbl[k].raddr = 16'h0120 + 16'(2 * (k - 1));
      if (k >= 2) begin
        tbl[k].valid = 1'b1;
        tbl[k].mdata = 16'hA000 + 16'(k - 2);
        tbl[k].wd = 1'b1;
        tbl[k].fa = 16'h0120 + 16'(2 * (k - 2));
        tbl[k].fd = 16'hA000 + 16'(k - 2);
      end
    end
    tbl[3].miss = 1'b1; tbl[3].maddr = 16'h8000;
    tbl[9] = '{1'b0, 16'h0, 1'b1, 16'hA007, 1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h012E, 16'hA007};
    tbl[10] = '{1'b0, 16'h0, 1'b1, 16'hBEEF, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0120, 16'h0};
    tbl[11] = '{1'b0, 16'h0, 1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0};

    for (int r = 0; r < 13; r++) begin
      miss_detected = tbl[r].miss;
      miss_address = tbl[r].maddr;
      memory_data_valid = tbl[r].valid;
      memory_data = tbl[r].mdata;
      @(negedge clk);
      chk($sformatf("tbl%0d_busy", r), {31'd0, fsm_busy}, {31'd0, tbl[r].busy});
      chk($sformatf("tbl%0d_read", r), {31'd0, memory_read}, {31'd0, tbl[r].rd});
      chk($sformatf("tbl%0d_maddr", r), {16'd0, memory_address}, {16'd0, tbl[r].raddr});
      chk($sformatf("tbl%0d_wd", r), {31'd0, write_data_array}, {31'd0, tbl[r].wd});
      chk($sformatf("tbl%0d_wt", r), {31'd0, write_tag_array}, {31'd0, tbl[r].wt});
      chk($sformatf("tbl%0d_fa", r), {16'd0, cache_fill_address}, {16'd0, tbl[r].fa});
      chk($sformatf("tbl%0d_fd", r), {16'd0, cache_fill_data}, {16'd0, tbl[r].fd});
      @(posedge clk);
      #1;
    end
    do_reset();

    // Basic fill, L=4, miss at 0x3A56: 14 busy cycles.
    run_fill(16'h3A56, 4, 20, 0, 0, 1'b0, -1, 16'h0, 1'b0, 16'h0);
    check_fill("basic", 16'h3A50, 14);
    chk("cache_hit_3a5c", {31'd0, c_val[7'h25] && (c_tag[7'h25] == 5'h07)}, 32'd1);
    chk("cache_data_3a5c", {16'd0, c_data[7'h25][3'd6]}, 32'h1006);
    chk("cache_miss_4250", {31'd0, c_val[7'h25] && (c_tag[7'h25] == 5'h08)}, 32'd0);

    // Irregular valids: 3-cycle gap after the 4th word, spurious valids afterwards.
    run_fill(16'h1236, 4, 24, 4, 3, 1'b1, -1, 16'h0, 1'b0, 16'h0);
    check_fill("irregular", 16'h1230, 17);

    // Miss while busy is ignored.
    run_fill(16'h3A56, 4, 20, 0, 0, 1'b0, 5, 16'h8000, 1'b0, 16'h0);
    check_fill("miss_busy", 16'h3A50, 14);

    // Reset mid-fill after 3 data writes.
    clear_sb();
    lat = 4;
    cycle_auto(1'b1, 16'h3A56);
    for (int k = 0; k < 20 && wr_cnt < 3; k++) cycle_auto(1'b0, 16'h0);
    chk("midreset_reached_3_writes", 32'(wr_cnt), 32'd3);
    miss_detected = 1'b0;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    chk("midreset_no_tag", 32'(tag_log.size()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_fill(16'h0010, 4, 20, 0, 0, 1'b0, -1, 16'h0, 1'b0, 16'h0);
    check_fill("after_reset", 16'h0010, 14);

    // Back-to-back: new miss in the first IDLE cycle after TAG.
    run_fill(16'h3A56, 1, 30, 0, 0, 1'b0, -1, 16'h0, 1'b1, 16'hFFF0);
    chk("b2b_busy_cycles", 32'(busy_cnt), 32'd22);
    chk("b2b_nreads", 32'(rd_log.size()), 32'd16);
    check_reads("b2b_read_a", 16'h3A50, 0);
    check_reads("b2b_read_b", 16'hFFF0, 8);
    chk("b2b_nwrites", 32'(wr_cnt), 32'd16);
    chk("b2b_ntags", 32'(tag_log.size()), 32'd2);
    if (tag_log.size() == 2) begin
      chk("b2b_tag0", {16'd0, tag_log[0]}, 32'h3A50);
      chk("b2b_tag1", {16'd0, tag_log[1]}, 32'hFFF0);
    end
    chk("b2b_pending_writes", 32'(exp_wr.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Miss handler for the direct-mapped instruction/data cache: on a cache miss it reads the full 8-word (16-byte) block from main memory and streams the words into the cache data array. It then writes the tag and releases the pipeline stall. It sits between the cache (consumes its `cache_miss`, drives its `data_write`/`tag_write`/`address`/`data_in` during a fill) and the multi-cycle main memory.

## Interface
- No parameters. Geometry is fixed: 16-bit byte address, 8 words of 16 bits per block, block offset `address[3:1]`, index `[10:4]`, tag `[15:11]`.
- `clk` in 1: single clock, all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `miss_detected` in 1: cache miss indication, from cache `cache_miss`.
- `miss_address` in 16: byte address that missed; sampled only in IDLE.
- `memory_data` in 16: read data from main memory.
- `memory_data_valid` in 1: `memory_data` carries the next outstanding read, returned in issue order.
- `fsm_busy` out 1: stall request to the pipeline.
- `memory_read` out 1: one-cycle read request to memory.
- `memory_address` out 16: word address for `memory_read`.
- `write_data_array` out 1: to cache `data_write`.
- `write_tag_array` out 1: to cache `tag_write`.
- `cache_fill_address` out 16: cache address during a fill (muxed over the pipeline address by the parent while `fsm_busy`).
- `cache_fill_data` out 16: to cache `data_in`.

## Operation
- States: IDLE, FILL, TAG. Registers: `base[15:4]`, `issue_cnt[3:0]`, `recv_cnt[3:0]`.
- IDLE:
  - On `miss_detected`=1: latch `base` = `miss_address[15:4]`, clear both counters, go to FILL.
  - `memory_data_valid` is ignored.
- FILL, issue side:
  - While `issue_cnt`<8: `memory_read`=1, `memory_address`={base, issue_cnt[2:0], 1'b0}.
  - `issue_cnt` increments each cycle. One request per cycle, 8 requests total, no gaps.
- FILL, receive side (independent of the issue side):
  - When `memory_data_valid`=1 and `recv_cnt`<8: `write_data_array`=1, `cache_fill_address`={base, recv_cnt[2:0], 1'b0}, `cache_fill_data`=`memory_data`.
  - `recv_cnt` increments.
  - The valid that brings `recv_cnt` to 8 moves the state to TAG.
- TAG, exactly one cycle:
  - `write_tag_array`=1, `cache_fill_address`={base, 4'b0}.
  - Then go to IDLE.
- `fsm_busy` = (state≠IDLE) | (state==IDLE & `miss_detected`). Combinational, so the pipeline stalls in the same cycle the miss is seen.
- `write_data_array`, `memory_read` and `write_tag_array` are never high outside their respective conditions. When idle, `cache_fill_address`/`cache_fill_data`/`memory_address` drive 0.
- Boundary behaviour:
  - `miss_detected` while in FILL or TAG is ignored and `base` does not change.
  - `memory_data_valid` beyond the 8th, or while in TAG, is ignored.
  - Valid data may arrive in the same cycle as later reads are issued. Valid data may not arrive before its read was issued; that is a memory protocol violation and is not checked.
  - Addresses never wrap: the block is aligned, so the word offset spans 0x0–0xE.
  - A `miss_detected` in the first IDLE cycle after TAG starts a new fill.
- Reset, asserted at any time including mid-fill: state IDLE, counters 0, `base` 0, all outputs 0 (`fsm_busy` follows `miss_detected`). The tag is not written, so the block is still a miss after reset.

## Timing
- Memory latency L ≥ 1: data for a read issued at cycle n returns at cycle n+L.
- Miss seen at cycle 0 (IDLE, `fsm_busy`=1):
  - Reads issue at cycles 1–8.
  - Data writes occur at cycles 1+L through 8+L.
  - TAG at cycle 9+L; IDLE at cycle 10+L.
- With L=4: `fsm_busy` is high for cycles 0–13 (14 cycles) and the pipeline retries at cycle 14.
- All outputs except `fsm_busy` are decoded from registered state, counters and the current `memory_data_valid`/`memory_data`. Data-write outputs are combinational from `memory_data_valid` in the same cycle.

## Test plan
- Basic fill, L=4, miss at address 0x3A56:
  - 8 reads to 0x3A50, 0x3A52, …, 0x3A5E on consecutive cycles.
  - Memory returns 0x1000+i; data writes 0x1000–0x1007 go to the same addresses in order.
  - `write_tag_array` pulses once with `cache_fill_address`=0x3A50.
  - `fsm_busy` is high for exactly 14 cycles.
- Irregular valids: memory holds `memory_data_valid` low for 3 cycles after the 4th word → `recv_cnt` holds, the remaining 4 writes land correctly, TAG follows the 8th valid. A 9th spurious valid produces no write.
- Miss while busy: `miss_detected` pulses with `miss_address`=0x8000 in the middle of a fill of 0x3A50 → no new reads; addresses stay 0x3A5x.
- Reset mid-fill: `rst_n` is dropped after 3 data writes → all outputs go to 0 asynchronously and the state is IDLE. After release, miss 0x0010 → a fresh fill with reads 0x0010–0x001E.
- Back-to-back misses: `miss_detected` is high in the cycle after TAG with address 0xFFF0 → new fill; the last read is 0xFFFE with no wrap, then the tag write goes to 0xFFF0.
- Integration with the cache: after a fill of 0x3A50 an access to 0x3A5C hits and returns 0x1006. An access to 0x4250 (same index, different tag) misses.
